lcd_spi_sink: RTL and testbench
===============================

// Module: lcd_spi_sink
// PURPOSE
// - Receive end of the 4-wire write-only SPI LCD link (SCL, CS, DC/RS, SDA, RESETN) driven by our LCD init/fill controller.
// - Oversamples the link on the system clock, deserialises MSB-first bytes and tags each byte as command or data.
// - Decodes the ST7789 subset we emit (SLPOUT, DISPON/OFF, MADCTL, COLMOD, CASET, RASET, RAMWR).
// - Emits addressed RGB565 pixel writes. Used as the on-chip display model in benches and as a link monitor on hardware.
// PARAMETERS
// SYNC_STAGES  2   flops per input synchroniser (min 2)
// COORD_W      9   width of column/row counters; CASET/RASET params truncated to this
// PORTS
// clk           in   1        system clock; must be >= 4x the SCL frequency
// reset         in   1        synchronous, active-high
// lcd_resetn    in   1        panel reset from master, active-low
// lcd_clk       in   1        SCL; SDA/DC sampled on rising edge
// lcd_cs        in   1        chip select, active-low
// lcd_rs        in   1        0 = command byte, 1 = data byte
// lcd_data      in   1        SDA, MSB first
// byte_valid    out  1        1-cycle pulse: byte_data/byte_is_data valid
// byte_data     out  8        last received byte
// byte_is_data  out  1        DC value sampled with bit 0 of that byte
// pix_valid     out  1        1-cycle pulse: pixel write
// pix_x         out  COORD_W  column of pixel
// pix_y         out  COORD_W  row of pixel
// pix_data      out  16       RGB565, first byte = [15:8]
// sleep_out     out  1        set by 0x11, cleared by panel reset
// disp_on       out  1        set by 0x29, cleared by 0x28 or panel reset
// madctl        out  8        last 0x36 parameter
// colmod        out  8        last 0x3A parameter
// framing_err   out  1        1-cycle pulse: CS deasserted mid-byte
// BEHAVIOUR
// - Reset (reset=1, or synchronised lcd_resetn=0): all outputs 0; xs=xe=ys=ye=0; cmd FSM to IDLE; bit count 0.
// - All five inputs pass through SYNC_STAGES flops. An SCL rise is sync_scl=1 with its previous value 0.
// - Deserialiser: active only while sync_cs=0; on each SCL rise, shift SDA in and increment bit_cnt.
//   On the 8th rise, byte_valid pulses the next clk with byte_is_data=DC sampled on that rise; bit_cnt -> 0.
// - sync_cs rising with bit_cnt!=0: framing_err pulses, partial byte is dropped, bit_cnt -> 0, cmd FSM state kept.
// - A command byte always re-enters the cmd FSM, abandoning any parameter/pixel in progress. Half-pixels are discarded.
// - Cmd FSM states: IDLE, CASET, RASET, RAMWR, REG1.
//   - 0x11: sleep_out=1. 0x29: disp_on=1. 0x28: disp_on=0.
//   - 0x36 / 0x3A -> REG1; the first data byte loads madctl / colmod, then IDLE.
//   - 0x2A -> CASET, param_idx=0. Data p0..p3 = xs_hi, xs_lo, xe_hi, xe_lo; the 16-bit value is truncated to COORD_W and committed on p3. Data after p3 is ignored.
//   - 0x2B -> RASET: same, for ys/ye.
//   - 0x2C -> RAMWR: x=xs, y=ys, phase=0.
//   - Other commands -> IDLE; data in IDLE is ignored, except byte_valid.
// - RAMWR pixel assembly: phase 0 captures hi; phase 1 asserts pix_valid in the same cycle as byte_valid.
//   - pix_x/pix_y are the current x/y; pix_data = {hi, byte}.
//   - Address advance: if x>=xe, x=xs and (y>=ye ? y=ys : y+1); else x+1. Covers full-frame wrap and xs>xe.
// - Latency: 8th SCL pin edge -> byte_valid/pix_valid = SYNC_STAGES+2 clk.
// - Outputs hold between pulses; byte_valid and framing_err never both 1 in the same cycle.
// TESTING
// - Cmd 0x11, then cmd 0x29 -> two byte_valid with byte_is_data=0, byte_data 0x11/0x29; sleep_out=1, disp_on=1.
// - Cmd 0x2A, data 00 28 01 17; cmd 0x2B, data 00 35 00 BB -> xs=0x028, xe=0x117, ys=0x035, ye=0x0BB.
// - Window 2x2 at (5,7), RAMWR + 5 pixels F8 00 / 07 E0 / 00 1F / 0F 50 / AA 55
//   -> pix (5,7)=F800, (6,7)=07E0, (5,8)=001F, (6,8)=0F50, (5,7)=AA55 (wrap).
// - 5 SCL rises, then CS high; then a full cmd 0x36 + data 0x70
//   -> framing_err pulse, no byte_valid for the partial byte, madctl=0x70.
// - RAMWR, data F8 only, then cmd 0x3A + data 0x05 -> no pix_valid, colmod=0x05; next RAMWR restarts at (xs,ys).
// - lcd_resetn low mid-RAMWR for 10 clk -> sleep_out, disp_on, madctl, windows all 0; no pix_valid until a new RAMWR.

Source files
------------

// File: rtl/lcd_spi_sink.sv
// Receive end of the 4-wire write-only SPI LCD link: oversampled deserialiser,
// ST7789 command-subset decoder and addressed RGB565 pixel-write generator.
module lcd_spi_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int COORD_W     = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lcd_resetn,
    input  logic               lcd_clk,
    input  logic               lcd_cs,
    input  logic               lcd_rs,
    input  logic               lcd_data,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               byte_is_data,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_data,
    output logic               sleep_out,
    output logic               disp_on,
    output logic [7:0]         madctl,
    output logic [7:0]         colmod,
    output logic               framing_err
);

    typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_REG1} state_t;

    // Synchroniser reset value is the idle link: {resetn, cs, scl, rs, sda}
    localparam logic [4:0] SYNC_IDLE = 5'b11000;

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic s_resetn, s_cs, s_scl, s_rs, s_sda, rst, scl_rise, cs_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        end else begin
            sync_q[0] <= {lcd_resetn, lcd_cs, lcd_clk, lcd_rs, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {s_resetn, s_cs, s_scl, s_rs, s_sda} = sync_q[SYNC_STAGES-1];
    // The synchronisers themselves only see the system reset, so the panel reset can release itself
    assign rst = reset | ~s_resetn;

    logic       scl_prev_q, cs_prev_q, done_q, dc_q, framing_err_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;

    assign scl_rise = s_scl & ~scl_prev_q;
    assign cs_rise  = s_cs & ~cs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_q    <= 1'b1;
            cs_prev_q     <= 1'b1;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            done_q        <= 1'b0;
            dc_q          <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            scl_prev_q    <= s_scl;
            cs_prev_q     <= s_cs;
            done_q        <= 1'b0;
            framing_err_q <= 1'b0;
            if (!s_cs && scl_rise) begin
                shreg_q   <= {shreg_q[6:0], s_sda};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    done_q <= 1'b1;
                    dc_q   <= s_rs;
                end
            end else if (cs_rise && bit_cnt_q != 3'd0) begin
                bit_cnt_q     <= '0;
                framing_err_q <= 1'b1;
            end
        end
    end

    state_t             state_q, state_d;
    logic [2:0]         pidx_q, pidx_d;
    logic               reg_sel_q, reg_sel_d, phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic [COORD_W-1:0] start_q, start_d, x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic               sleep_q, sleep_d, disp_q, disp_d;
    logic [7:0]         madctl_q, madctl_d, colmod_q, colmod_d;
    logic               bv_q, bv_d, bid_q, bid_d, pv_q, pv_d;
    logic [7:0]         bd_q, bd_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [15:0]        pd_q, pd_d, word;

    assign word = {hi_q, shreg_q};

    always_comb begin
        state_d   = state_q;
        pidx_d    = pidx_q;
        reg_sel_d = reg_sel_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        start_d   = start_q;
        x_d       = x_q;
        y_d       = y_q;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ys_d      = ys_q;
        ye_d      = ye_q;
        sleep_d   = sleep_q;
        disp_d    = disp_q;
        madctl_d  = madctl_q;
        colmod_d  = colmod_q;
        bv_d      = 1'b0;
        bd_d      = bd_q;
        bid_d     = bid_q;
        pv_d      = 1'b0;
        px_d      = px_q;
        py_d      = py_q;
        pd_d      = pd_q;
        if (done_q) begin
            bv_d  = 1'b1;
            bd_d  = shreg_q;
            bid_d = dc_q;
            if (!dc_q) begin
                state_d = S_IDLE;
                pidx_d  = '0;
                phase_d = 1'b0;
                case (shreg_q)
                    8'h11: sleep_d = 1'b1;
                    8'h29: disp_d  = 1'b1;
                    8'h28: disp_d  = 1'b0;
                    8'h36: begin state_d = S_REG1; reg_sel_d = 1'b0; end
                    8'h3A: begin state_d = S_REG1; reg_sel_d = 1'b1; end
                    8'h2A: state_d = S_CASET;
                    8'h2B: state_d = S_RASET;
                    8'h2C: begin state_d = S_RAMWR; x_d = xs_q; y_d = ys_q; end
                    default: ;
                endcase
            end else begin
                case (state_q)
                    S_REG1: begin
                        if (reg_sel_q) colmod_d = shreg_q;
                        else           madctl_d = shreg_q;
                        state_d = S_IDLE;
                    end
                    S_CASET, S_RASET: begin
                        case (pidx_q)
                            3'd0, 3'd2: begin hi_d = shreg_q; pidx_d = pidx_q + 3'd1; end
                            3'd1: begin start_d = word[COORD_W-1:0]; pidx_d = 3'd2; end
                            3'd3: begin
                                // Start and end land together so a window is never half-updated
                                if (state_q == S_CASET) begin
                                    xs_d = start_q; xe_d = word[COORD_W-1:0];
                                end else begin
                                    ys_d = start_q; ye_d = word[COORD_W-1:0];
                                end
                                pidx_d = 3'd4;
                            end
                            default: ;
                        endcase
                    end
                    S_RAMWR: begin
                        if (!phase_q) begin
                            hi_d    = shreg_q;
                            phase_d = 1'b1;
                        end else begin
                            pv_d    = 1'b1;
                            px_d    = x_q;
                            py_d    = y_q;
                            pd_d    = word;
                            phase_d = 1'b0;
                            if (x_q >= xe_q) begin
                                x_d = xs_q;
                                y_d = (y_q >= ye_q) ? ys_q : y_q + COORD_W'(1);
                            end else begin
                                x_d = x_q + COORD_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pidx_q    <= '0;
            reg_sel_q <= 1'b0;
            phase_q   <= 1'b0;
            hi_q      <= '0;
            start_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            xs_q      <= '0;
            xe_q      <= '0;
            ys_q      <= '0;
            ye_q      <= '0;
            sleep_q   <= 1'b0;
            disp_q    <= 1'b0;
            madctl_q  <= '0;
            colmod_q  <= '0;
            bv_q      <= 1'b0;
            bd_q      <= '0;
            bid_q     <= 1'b0;
            pv_q      <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            pd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pidx_q    <= pidx_d;
            reg_sel_q <= reg_sel_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            start_q   <= start_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            sleep_q   <= sleep_d;
            disp_q    <= disp_d;
            madctl_q  <= madctl_d;
            colmod_q  <= colmod_d;
            bv_q      <= bv_d;
            bd_q      <= bd_d;
            bid_q     <= bid_d;
            pv_q      <= pv_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pd_q      <= pd_d;
        end
    end

    assign byte_valid   = bv_q;
    assign byte_data    = bd_q;
    assign byte_is_data = bid_q;
    assign pix_valid    = pv_q;
    assign pix_x        = px_q;
    assign pix_y        = py_q;
    assign pix_data     = pd_q;
    assign sleep_out    = sleep_q;
    assign disp_on      = disp_q;
    assign madctl       = madctl_q;
    assign colmod       = colmod_q;
    assign framing_err  = framing_err_q;

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Directed bench for lcd_spi_sink: bit-banged SPI master, byte/pixel vector
// table plus hand-written framing, abort, latency and panel-reset sequences.
module tb_lcd_spi_sink;

    localparam int SYNC_STAGES = 2;
    localparam int COORD_W     = 9;

    logic               clk = 1'b0;
    logic               reset, lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;
    logic               byte_valid, byte_is_data, pix_valid, sleep_out, disp_on, framing_err;
    logic [7:0]         byte_data, madctl, colmod;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic [15:0]        pix_data;

    lcd_spi_sink #(.SYNC_STAGES(SYNC_STAGES), .COORD_W(COORD_W)) dut (
        .clk(clk), .reset(reset), .lcd_resetn(lcd_resetn), .lcd_clk(lcd_clk),
        .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .sleep_out(sleep_out), .disp_on(disp_on), .madctl(madctl), .colmod(colmod),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    // Monitor: counts pulses and latches the most recent event values
    int               cyc = 0, bv_cnt = 0, pv_cnt = 0, fe_cnt = 0, both_cnt = 0, bv_cyc = 0;
    logic [7:0]       m_b;
    logic             m_dc;
    logic [COORD_W-1:0] m_x, m_y;
    logic [15:0]      m_d;

    always @(negedge clk) begin
        cyc++;
        if (byte_valid) begin bv_cnt++; m_b = byte_data; m_dc = byte_is_data; bv_cyc = cyc; end
        if (pix_valid) begin pv_cnt++; m_x = pix_x; m_y = pix_y; m_d = pix_data; end
        if (framing_err) fe_cnt++;
        if (byte_valid && framing_err) both_cnt++;
    end

    int n_cmp = 0, n_fail = 0, rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // n bits of b MSB first inside one CS frame; n < 8 leaves a partial byte
    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        lcd_cs = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            lcd_rs   = dc;
            lcd_data = b[7-i];
            repeat (4) @(posedge clk);
            lcd_clk = 1'b1;
            rise_cyc = cyc;
            repeat (4) @(posedge clk);
            lcd_clk = 1'b0;
        end
        repeat (2) @(posedge clk);
        lcd_cs = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    typedef struct {
        logic               dc;
        logic [7:0]         b;
        logic               ep;
        logic [COORD_W-1:0] ex, ey;
        logic [15:0]        ed;
    } vec_t;

    vec_t vt[64];
    int   nv = 0;

    task automatic add(input logic dc, input logic [7:0] b, input logic ep,
                       input logic [COORD_W-1:0] ex, input logic [COORD_W-1:0] ey,
                       input logic [15:0] ed);
        vt[nv] = '{dc, b, ep, ex, ey, ed};
        nv++;
    endtask

    task automatic cmd(input logic [7:0] b);  add(1'b0, b, 1'b0, '0, '0, '0); endtask
    task automatic dat(input logic [7:0] b);  add(1'b1, b, 1'b0, '0, '0, '0); endtask

    int b0, p0, f0;

    initial begin
        cmd(8'h11); cmd(8'h29);
        cmd(8'h2A); dat(8'h00); dat(8'h28); dat(8'h01); dat(8'h17); dat(8'hFF);
        cmd(8'h2B); dat(8'h00); dat(8'h35); dat(8'h00); dat(8'hBB);
        cmd(8'h2C); dat(8'h12); add(1'b1, 8'h34, 1'b1, 9'h028, 9'h035, 16'h1234);
        dat(8'h56); add(1'b1, 8'h78, 1'b1, 9'h029, 9'h035, 16'h5678);
        // 2x2 window at (5,7); xe high byte exercises truncation to COORD_W
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'hFE); dat(8'h06);
        cmd(8'h2B); dat(8'h00); dat(8'h07); dat(8'h00); dat(8'h08);
        cmd(8'h2C);
        dat(8'hF8); add(1'b1, 8'h00, 1'b1, 9'd5, 9'd7, 16'hF800);
        dat(8'h07); add(1'b1, 8'hE0, 1'b1, 9'd6, 9'd7, 16'h07E0);
        dat(8'h00); add(1'b1, 8'h1F, 1'b1, 9'd5, 9'd8, 16'h001F);
        dat(8'h0F); add(1'b1, 8'h50, 1'b1, 9'd6, 9'd8, 16'h0F50);
        dat(8'hAA); add(1'b1, 8'h55, 1'b1, 9'd5, 9'd7, 16'hAA55);

        reset = 1'b1; lcd_resetn = 1'b1; lcd_clk = 1'b0; lcd_cs = 1'b1; lcd_rs = 1'b0; lcd_data = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_byte_valid", byte_valid, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_sleep", sleep_out, 0);
        check("rst_disp", disp_on, 0);
        check("rst_madctl", madctl, 0);
        check("rst_colmod", colmod, 0);
        check("rst_framing", framing_err, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < nv; i++) begin
            b0 = bv_cnt; p0 = pv_cnt;
            send(vt[i].dc, vt[i].b);
            check($sformatf("v%0d_bv_cnt", i), bv_cnt - b0, 1);
            check($sformatf("v%0d_byte", i), m_b, vt[i].b);
            check($sformatf("v%0d_dc", i), m_dc, vt[i].dc);
            check($sformatf("v%0d_pv_cnt", i), pv_cnt - p0, vt[i].ep ? 1 : 0);
            if (vt[i].ep) begin
                check($sformatf("v%0d_pix_x", i), m_x, vt[i].ex);
                check($sformatf("v%0d_pix_y", i), m_y, vt[i].ey);
                check($sformatf("v%0d_pix_data", i), m_d, vt[i].ed);
            end
        end
        check("sleep_out_set", sleep_out, 1);
        check("disp_on_set", disp_on, 1);
        check("latency", bv_cyc - rise_cyc, SYNC_STAGES + 2);

        send(1'b0, 8'h28);
        check("disp_off", disp_on, 0);

        // Partial byte dropped by CS, then a clean MADCTL write
        b0 = bv_cnt; f0 = fe_cnt;
        send_bits(1'b0, 8'hA5, 5);
        check("frame_err_cnt", fe_cnt - f0, 1);
        check("frame_no_byte", bv_cnt - b0, 0);
        send(1'b0, 8'h36); send(1'b1, 8'h70);
        check("madctl_after_err", madctl, 8'h70);
        check("frame_err_once", fe_cnt - f0, 1);

        // Half pixel abandoned by a command; next RAMWR restarts at window origin
        p0 = pv_cnt;
        send(1'b0, 8'h2C); send(1'b1, 8'hF8);
        send(1'b0, 8'h3A); send(1'b1, 8'h05);
        check("abort_no_pix", pv_cnt - p0, 0);
        check("colmod", colmod, 8'h05);
        send(1'b0, 8'h2C); send(1'b1, 8'h11); send(1'b1, 8'h22);
        check("restart_pix_cnt", pv_cnt - p0, 1);
        check("restart_x", m_x, 5);
        check("restart_y", m_y, 7);
        check("restart_data", m_d, 16'h1122);

        // Panel reset in the middle of a pixel
        send(1'b0, 8'h29); send(1'b0, 8'h11);
        send(1'b0, 8'h2C); send(1'b1, 8'hAB);
        lcd_resetn = 1'b0;
        repeat (10) @(posedge clk);
        lcd_resetn = 1'b1;
        repeat (5) @(posedge clk);
        check("prst_sleep", sleep_out, 0);
        check("prst_disp", disp_on, 0);
        check("prst_madctl", madctl, 0);
        check("prst_colmod", colmod, 0);
        p0 = pv_cnt;
        send(1'b1, 8'hCD); send(1'b1, 8'hEF);
        check("prst_no_pix", pv_cnt - p0, 0);
        send(1'b0, 8'h2C); send(1'b1, 8'h12); send(1'b1, 8'h34);
        check("prst_pix_cnt", pv_cnt - p0, 1);
        check("prst_pix_x", m_x, 0);
        check("prst_pix_y", m_y, 0);
        check("prst_pix_data", m_d, 16'h1234);

        check("bv_fe_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
